// File: rtl/cipher_char_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cipher_char_feeder
// Purpose  : Front end for the cipher-letter decoder. Folds ASCII lowercase
//            to uppercase and forwards only the 12 legal cipher letters
//            (E T A O I N S H R D L U). Spaces and FLUSH close the current
//            word by tagging its last letter with an end-of-word flag.
//            Everything else is dropped and counted. Results are buffered in
//            a show-ahead FIFO.
// Ports    : CLK, RST_N (async, active-low)
//            IN_VALID/IN_READY/IN_CHAR  : raw character input handshake
//            FLUSH                      : level request to close pending word
//            OUT_VALID/OUT_READY        : FIFO head handshake
//            CIPHER/OUT_EOW             : FIFO head letter and end-of-word
//            COUNT                      : FIFO occupancy
//            LET_CNT/REJ_CNT            : saturating letter/reject counters
// Revision : 1.0 - initial release
// ============================================================================
module cipher_char_feeder #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [7:0]               IN_CHAR,
  input  logic                     FLUSH,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [7:0]               CIPHER,
  output logic                     OUT_EOW,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic [CNT_W-1:0]         LET_CNT,
  output logic [CNT_W-1:0]         REJ_CNT
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] C_FULL = (PTR_W+1)'(DEPTH);

  // Each FIFO entry is {eow, letter}
  logic [8:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             stg_v_q, stg_v_d;
  logic [7:0]       stg_ch_q, stg_ch_d;
  logic [CNT_W-1:0] let_q, let_d, rej_q, rej_d;

  logic       w_full, w_empty, w_xfer, w_pop, w_push, w_push_eow;
  logic       w_is_letter, w_is_space, w_let_inc, w_rej_inc;
  logic [7:0] w_folded;

  assign w_full   = (count_q == C_FULL);
  assign w_empty  = (count_q == '0);
  assign IN_READY = RST_N & ~w_full & ~FLUSH;
  assign w_xfer   = IN_VALID & IN_READY;
  assign w_pop    = ~w_empty & OUT_READY;

  assign w_folded   = (IN_CHAR >= 8'd97 && IN_CHAR <= 8'd122) ? IN_CHAR - 8'd32 : IN_CHAR;
  assign w_is_space = (IN_CHAR == 8'd32);

  always_comb begin
    w_is_letter = 1'b0;
    case (w_folded)
      8'd69, 8'd84, 8'd65, 8'd79, 8'd73, 8'd78,
      8'd83, 8'd72, 8'd82, 8'd68, 8'd76, 8'd85: w_is_letter = 1'b1;
      default:                                  w_is_letter = 1'b0;
    endcase
  end

  // The staged letter is held back until we learn whether it ends a word.
  // FLUSH and an input transfer are mutually exclusive because FLUSH forces
  // IN_READY low, so the two branches never compete for the FIFO write.
  always_comb begin
    w_push     = 1'b0;
    w_push_eow = 1'b0;
    w_let_inc  = 1'b0;
    w_rej_inc  = 1'b0;
    stg_v_d    = stg_v_q;
    stg_ch_d   = stg_ch_q;
    if (w_xfer) begin
      if (w_is_letter) begin
        w_let_inc = 1'b1;
        w_push    = stg_v_q;
        stg_v_d   = 1'b1;
        stg_ch_d  = w_folded;
      end else if (w_is_space) begin
        // A space with nothing staged collapses silently
        w_push     = stg_v_q;
        w_push_eow = 1'b1;
        stg_v_d    = 1'b0;
      end else begin
        w_rej_inc = 1'b1;
      end
    end else if (FLUSH && stg_v_q && !w_full) begin
      w_push     = 1'b1;
      w_push_eow = 1'b1;
      stg_v_d    = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    let_d = (w_let_inc && (let_q != '1)) ? let_q + 1'b1 : let_q;
    rej_d = (w_rej_inc && (rej_q != '1)) ? rej_q + 1'b1 : rej_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stg_v_q  <= 1'b0;
      stg_ch_q <= '0;
      let_q    <= '0;
      rej_q    <= '0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= {w_push_eow, stg_ch_q};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (w_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q  <= count_d;
      stg_v_q  <= stg_v_d;
      stg_ch_q <= stg_ch_d;
      let_q    <= let_d;
      rej_q    <= rej_d;
    end
  end

  assign OUT_VALID         = ~w_empty;
  assign {OUT_EOW, CIPHER} = mem_q[rd_ptr_q];
  assign COUNT             = count_q;
  assign LET_CNT           = let_q;
  assign REJ_CNT           = rej_q;

endmodule
`default_nettype wire

// File: tb/tb_cipher_char_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cipher_char_feeder
// Purpose  : Scoreboard bench for cipher_char_feeder. Stimulus drives one
//            cycle at a time and pushes expected FIFO entries into a queue.
//            A negedge monitor pops and compares whenever the DUT hands out
//            an entry.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cipher_char_feeder;

  localparam int DEPTH = 8;
  localparam int CNT_W = 6;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int SATV  = (1 << CNT_W) - 1;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          IN_VALID = 1'b0;
  logic          FLUSH = 1'b0;
  logic          OUT_READY = 1'b0;
  logic [7:0]    IN_CHAR = 8'd0;
  logic          IN_READY, OUT_VALID, OUT_EOW;
  logic [7:0]    CIPHER;
  logic [CW-1:0] COUNT;
  logic [CNT_W-1:0] LET_CNT, REJ_CNT;

  cipher_char_feeder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_CHAR(IN_CHAR), .FLUSH(FLUSH), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .CIPHER(CIPHER), .OUT_EOW(OUT_EOW),
    .COUNT(COUNT), .LET_CNT(LET_CNT), .REJ_CNT(REJ_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] ch;
    logic       eow;
  } ent_t;

  int   checks = 0;
  int   errors = 0;
  int   popped = 0;
  ent_t sbq[$];

  // Reference model: the pending (not yet word-closed) letter, expected
  // occupancy and raw counter totals.
  bit         pend_v;
  logic [7:0] pend_ch;
  int         exp_cnt, exp_let, exp_rej;

  function automatic logic [7:0] fold(input logic [7:0] c);
    return (c >= "a" && c <= "z") ? c - 8'd32 : c;
  endfunction

  function automatic bit is_legal(input logic [7:0] c);
    string s = "ETAOINSHRDLU";
    for (int i = 0; i < s.len(); i++) if (s[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int sat(input int v);
    return (v > SATV) ? SATV : v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    sbq.delete();
    pend_v  = 1'b0;
    pend_ch = 8'd0;
    exp_cnt = 0;
    exp_let = 0;
    exp_rej = 0;
    popped  = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out_valid"}, OUT_VALID, 0);
    chk({tag, "_count"},     COUNT, 0);
    chk({tag, "_let"},       LET_CNT, 0);
    chk({tag, "_rej"},       REJ_CNT, 0);
    chk({tag, "_in_ready"},  IN_READY, 0);
    chk({tag, "_cipher"},    CIPHER, 0);
    chk({tag, "_eow"},       OUT_EOW, 0);
  endtask

  // One clock cycle of stimulus; called right after a rising edge.
  task automatic tick(input bit v, input logic [7:0] c, input bit fl,
                      input bit rdy, output bit acc);
    bit         full, pred_rdy, push;
    ent_t       e;
    logic [7:0] f;
    IN_VALID  = v;
    IN_CHAR   = c;
    FLUSH     = fl;
    OUT_READY = rdy;
    full      = (exp_cnt == DEPTH);
    pred_rdy  = !full && !fl;
    acc       = v && pred_rdy;
    @(negedge CLK);
    chk("in_ready", IN_READY, pred_rdy);
    @(posedge CLK);
    push = 1'b0;
    e    = '0;
    if (acc) begin
      f = fold(c);
      if (is_legal(f)) begin
        exp_let++;
        if (pend_v) begin push = 1'b1; e.ch = pend_ch; e.eow = 1'b0; end
        pend_v  = 1'b1;
        pend_ch = f;
      end else if (c == " ") begin
        if (pend_v) begin push = 1'b1; e.ch = pend_ch; e.eow = 1'b1; end
        pend_v = 1'b0;
      end else begin
        exp_rej++;
      end
    end else if (fl && pend_v && !full) begin
      push   = 1'b1;
      e.ch   = pend_ch;
      e.eow  = 1'b1;
      pend_v = 1'b0;
    end
    if (exp_cnt > 0 && rdy) exp_cnt--;
    if (push) begin sbq.push_back(e); exp_cnt++; end
    #1;
    chk("count",     COUNT, exp_cnt);
    chk("out_valid", OUT_VALID, (exp_cnt > 0) ? 1 : 0);
    chk("let_cnt",   LET_CNT, sat(exp_let));
    chk("rej_cnt",   REJ_CNT, sat(exp_rej));
  endtask

  task automatic send(input logic [7:0] c, input bit rdy);
    bit acc;
    int n = 0;
    do begin
      tick(1'b1, c, 1'b0, rdy, acc);
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: char %0d never accepted", c);
    end
  endtask

  task automatic send_str(input string s, input bit rdy);
    for (int i = 0; i < s.len(); i++) send(s[i], rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    bit acc;
    for (int i = 0; i < n; i++) tick(1'b0, 8'd0, 1'b0, rdy, acc);
  endtask

  // Synchronous-looking entry point, asynchronous assertion mid-cycle.
  task automatic do_reset(input string tag);
    #3;
    RST_N = 1'b0;
    IN_VALID = 1'b0; FLUSH = 1'b0; OUT_READY = 1'b0;
    #1;
    chk_zero(tag);
    reset_model();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  // Monitor: compares every handed-out entry against the scoreboard.
  always @(negedge CLK) begin : mon
    ent_t e;
    if (RST_N && OUT_VALID) begin
      chk("legal_code", is_legal(CIPHER), 1);
      if (OUT_READY) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: cipher %0d with empty scoreboard", CIPHER);
        end else begin
          e = sbq.pop_front();
          popped++;
          chk("cipher", CIPHER, e.ch);
          chk("eow", OUT_EOW, e.eow);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit         acc;
    int         r;
    logic [7:0] c;
    string      legal = "ETAOINSHRDLU";
    reset_model();
    repeat (3) @(posedge CLK);
    #1;
    chk_zero("reset");
    RST_N = 1'b1;

    // 1: single word closed by a space
    send_str("HELLO ", 1'b1);
    idle(3, 1'b1);
    chk("t1_let", LET_CNT, 5);
    chk("t1_rej", REJ_CNT, 0);
    chk("t1_popped", popped, 5);

    // 2: lowercase word closed by FLUSH (IN_READY low that cycle)
    send_str("tin", 1'b1);
    tick(1'b0, 8'd0, 1'b1, 1'b1, acc);
    idle(3, 1'b1);
    chk("t2_popped", popped, 8);

    // 3: rejects only
    do_reset("t3_rst");
    send_str("Bz1?", 1'b1);
    idle(2, 1'b1);
    chk("t3_rej", REJ_CNT, 4);
    chk("t3_let", LET_CNT, 0);
    chk("t3_valid", OUT_VALID, 0);

    // 4: fill the FIFO, stall, then free one slot
    do_reset("t4_rst");
    send_str("ETAOINSHR", 1'b0);
    chk("t4_count_full", COUNT, DEPTH);
    tick(1'b1, "D", 1'b0, 1'b0, acc);
    tick(1'b1, "D", 1'b0, 1'b1, acc);
    tick(1'b1, "D", 1'b0, 1'b0, acc);
    chk("t4_count_refill", COUNT, DEPTH);
    chk("t4_let", LET_CNT, 10);
    idle(10, 1'b1);
    tick(1'b0, 8'd0, 1'b1, 1'b1, acc);
    idle(3, 1'b1);
    chk("t4_popped", popped, 10);

    // 5: leading and repeated spaces collapse
    do_reset("t5_rst");
    send_str("  A   T ", 1'b1);
    idle(3, 1'b1);
    chk("t5_popped", popped, 2);
    chk("t5_let", LET_CNT, 2);

    // 6: asynchronous reset mid-stream discards everything
    do_reset("t6_rst0");
    send_str("ROUND", 1'b0);
    chk("t6_loaded", COUNT, 4);
    do_reset("t6_async");
    send_str("U ", 1'b1);
    idle(3, 1'b1);
    chk("t6_popped", popped, 1);

    // Random traffic, long enough to saturate the narrow counters
    do_reset("rnd_rst");
    for (int i = 0; i < 900; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: c = legal[$urandom_range(0, 11)];
        4, 5:       c = legal[$urandom_range(0, 11)] + 8'd32;
        6, 9:       c = " ";
        7:          c = 8'(97 + $urandom_range(0, 25));
        default:    c = 8'($urandom_range(0, 255));
      endcase
      tick(($urandom_range(0, 3) != 0), c, ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 6), acc);
    end
    for (int i = 0; i < 12; i++) tick(1'b0, 8'd0, 1'b1, 1'b1, acc);
    idle(DEPTH + 4, 1'b1);
    chk("rnd_drained", sbq.size(), 0);
    chk("rnd_let_sat", LET_CNT, sat(exp_let));
    chk("rnd_rej_sat", REJ_CNT, sat(exp_rej));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
